// File: rtl/rtc_set_entry.sv
// Digit-by-digit HH:MM:SS entry for an RTC. Each keyed BCD digit is range-checked
// against its position; a completed session emits a one-cycle load with binary values.
module rtc_set_entry #(
    parameter int unsigned HOUR_MAX = 23
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_enter,
    input  logic       key_cancel,
    input  logic [3:0] digit,
    output logic [5:0] hour_load,
    output logic [5:0] min_load,
    output logic [5:0] sec_load,
    output logic       load,
    output logic       busy,
    output logic [2:0] pos,
    output logic       entry_err
);

    // State codes double as the entry position, so pos needs no decode for H_T..S_O.
    localparam logic [2:0] StHTens  = 3'd0;
    localparam logic [2:0] StHOnes  = 3'd1;
    localparam logic [2:0] StMTens  = 3'd2;
    localparam logic [2:0] StMOnes  = 3'd3;
    localparam logic [2:0] StSTens  = 3'd4;
    localparam logic [2:0] StSOnes  = 3'd5;
    localparam logic [2:0] StCommit = 3'd6;
    localparam logic [2:0] StIdle   = 3'd7;

    logic [2:0] state_q, state_d;
    logic [3:0] ht_q, ho_q, mt_q, mo_q, st_q, so_q;
    logic [5:0] hour_q, min_q, sec_q;
    logic       err_q;
    logic       digit_ok;
    logic       accept;
    logic       reject;
    logic [5:0] hour_now, min_now, sec_now;

    always_comb begin
        digit_ok = 1'b0;
        if (digit <= 4'd9) begin
            case (state_q)
                StHTens:          digit_ok = (7'(digit) * 7'd10) <= 7'(HOUR_MAX);
                StHOnes:          digit_ok = (7'(ht_q) * 7'd10 + 7'(digit)) <= 7'(HOUR_MAX);
                StMTens, StSTens: digit_ok = (digit <= 4'd5);
                StMOnes, StSOnes: digit_ok = 1'b1;
                default:          digit_ok = 1'b0;
            endcase
        end
    end

    // Cancel outranks enter, so a rejected digit never flags alongside an abort.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        case (state_q)
            StIdle: begin
                if (key_start) state_d = StHTens;
            end
            StCommit: state_d = StIdle;
            default: begin
                if (key_cancel) begin
                    state_d = StIdle;
                end else if (key_enter) begin
                    if (digit_ok) begin
                        accept  = 1'b1;
                        state_d = state_q + 3'd1;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
        endcase
    end

    assign hour_now = 6'(7'(ht_q) * 7'd10 + 7'(ho_q));
    assign min_now  = 6'(7'(mt_q) * 7'd10 + 7'(mo_q));
    assign sec_now  = 6'(7'(st_q) * 7'd10 + 7'(so_q));

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
            ht_q    <= 4'd0;
            ho_q    <= 4'd0;
            mt_q    <= 4'd0;
            mo_q    <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
            hour_q  <= 6'd0;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            err_q   <= reject;
            if (state_q == StIdle && key_start) begin
                ht_q <= 4'd0;
                ho_q <= 4'd0;
                mt_q <= 4'd0;
                mo_q <= 4'd0;
                st_q <= 4'd0;
                so_q <= 4'd0;
            end
            if (accept) begin
                case (state_q)
                    StHTens: ht_q <= digit;
                    StHOnes: ho_q <= digit;
                    StMTens: mt_q <= digit;
                    StMOnes: mo_q <= digit;
                    StSTens: st_q <= digit;
                    default: so_q <= digit;
                endcase
            end
            if (state_q == StCommit) begin
                hour_q <= hour_now;
                min_q  <= min_now;
                sec_q  <= sec_now;
            end
        end
    end

    // During COMMIT the fresh values are shown directly so they are valid with load.
    assign load      = (state_q == StCommit);
    assign busy      = (state_q != StIdle);
    assign pos       = load ? 3'd5 : state_q;
    assign entry_err = err_q;
    assign hour_load = load ? hour_now : hour_q;
    assign min_load  = load ? min_now  : min_q;
    assign sec_load  = load ? sec_now  : sec_q;

endmodule

// File: tb/tb_rtc_set_entry.sv
// Directed bench for rtc_set_entry; a second instance with HOUR_MAX=12 shares the stimulus.
module tb_rtc_set_entry;

    logic       clk = 1'b0;
    logic       rst, key_start, key_enter, key_cancel;
    logic [3:0] digit;
    logic [5:0] hour_load, min_load, sec_load;
    logic       load, busy, entry_err;
    logic [2:0] pos;
    logic [5:0] hour12, min12, sec12;
    logic       load12, busy12, err12;
    logic [2:0] pos12;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rtc_set_entry dut (
        .CLOCK_50(clk), .rst(rst), .key_start(key_start), .key_enter(key_enter),
        .key_cancel(key_cancel), .digit(digit), .hour_load(hour_load),
        .min_load(min_load), .sec_load(sec_load), .load(load), .busy(busy),
        .pos(pos), .entry_err(entry_err)
    );

    rtc_set_entry #(.HOUR_MAX(12)) dut12 (
        .CLOCK_50(clk), .rst(rst), .key_start(key_start), .key_enter(key_enter),
        .key_cancel(key_cancel), .digit(digit), .hour_load(hour12),
        .min_load(min12), .sec_load(sec12), .load(load12), .busy(busy12),
        .pos(pos12), .entry_err(err12)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start();
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
    endtask

    task automatic enter(input logic [3:0] d);
        key_enter = 1'b1;
        digit     = d;
        tick();
        key_enter = 1'b0;
    endtask

    initial begin
        rst = 1'b1; key_start = 1'b0; key_enter = 1'b0; key_cancel = 1'b0; digit = 4'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_pos", pos, 7);
        chk("rst_busy", busy, 0);
        chk("rst_load", load, 0);
        chk("rst_err", entry_err, 0);
        chk("rst_hour", hour_load, 0);
        chk("rst_min", min_load, 0);
        chk("rst_sec", sec_load, 0);
        enter(4'd3);
        chk("idle_enter_ignored", busy, 0);

        // 13:45:09
        start();
        chk("t1_pos0", pos, 0);
        chk("t1_busy", busy, 1);
        enter(4'd1); chk("t1_pos1", pos, 1);
        enter(4'd3); chk("t1_pos2", pos, 2);
        enter(4'd4); chk("t1_pos3", pos, 3);
        enter(4'd5); chk("t1_pos4", pos, 4);
        enter(4'd0); chk("t1_pos5", pos, 5);
        chk("t1_noload", load, 0);
        enter(4'd9);
        chk("t1_load", load, 1);
        chk("t1_hour", hour_load, 13);
        chk("t1_min", min_load, 45);
        chk("t1_sec", sec_load, 9);
        chk("t1_commit_pos", pos, 5);
        tick();
        chk("t1_load_off", load, 0);
        chk("t1_busy_off", busy, 0);
        chk("t1_pos_idle", pos, 7);
        chk("t1_hour_hold", hour_load, 13);

        // Hour ones bounded by HOUR_MAX=23
        start();
        enter(4'd2);
        enter(4'd4);
        chk("t2_err", entry_err, 1);
        chk("t2_pos_stuck", pos, 1);
        tick();
        chk("t2_err_once", entry_err, 0);
        enter(4'd3); chk("t2_pos2", pos, 2);
        enter(4'd0);
        enter(4'd0);
        enter(4'd5);
        enter(4'd9);
        chk("t2_load", load, 1);
        chk("t2_hour", hour_load, 23);
        chk("t2_min", min_load, 0);
        chk("t2_sec", sec_load, 59);
        tick();

        // Bad minute tens and non-BCD digit
        start();
        enter(4'd1);
        enter(4'd2);
        enter(4'd6);
        chk("t3_mt_err", entry_err, 1);
        chk("t3_mt_pos", pos, 2);
        enter(4'd3); chk("t3_pos3", pos, 3);
        enter(4'hB);
        chk("t3_bcd_err", entry_err, 1);
        chk("t3_bcd_pos", pos, 3);
        enter(4'd7);
        enter(4'd5);
        enter(4'd5);
        chk("t3_load", load, 1);
        chk("t3_hour", hour_load, 12);
        chk("t3_min", min_load, 37);
        chk("t3_sec", sec_load, 55);
        tick();

        // Restart ignored mid-session, cancel beats enter
        start();
        enter(4'd0);
        enter(4'd8);
        enter(4'd3);
        enter(4'd0);
        start();
        chk("t4_start_ignored", pos, 4);
        key_cancel = 1'b1;
        enter(4'd1);
        key_cancel = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_pos", pos, 7);
        chk("t4_load", load, 0);
        chk("t4_err", entry_err, 0);
        chk("t4_hour", hour_load, 12);
        chk("t4_min", min_load, 37);
        chk("t4_sec", sec_load, 55);
        tick();
        chk("t4_no_late_load", load, 0);

        // Reset during COMMIT
        start();
        enter(4'd2);
        enter(4'd1);
        enter(4'd5);
        enter(4'd9);
        enter(4'd5);
        enter(4'd9);
        chk("t5_load", load, 1);
        chk("t5_hour", hour_load, 21);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_load_off", load, 0);
        chk("t5_hour", hour_load, 0);
        chk("t5_min", min_load, 0);
        chk("t5_sec", sec_load, 0);
        chk("t5_pos", pos, 7);
        chk("t5_busy", busy, 0);
        tick();
        chk("t5_still_zero", hour_load, 0);

        // HOUR_MAX=12 instance
        start();
        enter(4'd1);
        chk("t6_pos1", pos12, 1);
        enter(4'd3);
        chk("t6_err", err12, 1);
        chk("t6_pos_stuck", pos12, 1);
        enter(4'd2);
        chk("t6_pos2", pos12, 2);
        enter(4'd0);
        enter(4'd0);
        enter(4'd0);
        enter(4'd0);
        chk("t6_load", load12, 1);
        chk("t6_hour", hour12, 12);
        chk("t6_min", min12, 0);
        chk("t6_sec", sec12, 0);
        tick();
        chk("t6_idle", pos12, 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rtc_set_entry.md
RTC_SET_ENTRY -- requirements
Module: rtc_set_entry

Interface
REQ-001 Parameter: HOUR_MAX, default 23, largest legal hour value (range 1..63).
REQ-002 CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 key_start  input  1  single-cycle pulse, debounced; begins a time-entry session.
REQ-005 key_enter  input  1  single-cycle pulse, debounced; offers digit for the current position.
REQ-006 key_cancel  input  1  single-cycle pulse, debounced; aborts the session.
REQ-007 digit  input  4  BCD digit offered with key_enter.
REQ-008 hour_load  output  6  binary hour value, 0..HOUR_MAX.
REQ-009 min_load  output  6  binary minute value, 0..59.
REQ-010 sec_load  output  6  binary second value, 0..59.
REQ-011 load  output  1  single-cycle pulse; *_load values are valid while it is high.
REQ-012 busy  output  1  high while a session is active (any state except IDLE).
REQ-013 pos  output  3  current entry position: 0=H tens, 1=H ones, 2=M tens, 3=M ones, 4=S tens, 5=S ones, 7=idle.
REQ-014 entry_err  output  1  single-cycle pulse flagging a rejected digit.

Function
REQ-015 The FSM SHALL have states IDLE, H_T, H_O, M_T, M_O, S_T, S_O and COMMIT, one-hot or encoded.
REQ-016 IDLE: key_start SHALL move to H_T and clear all six captured digit registers to 0; key_enter and key_cancel SHALL be ignored.
REQ-017 In H_T..S_O, key_enter with a valid digit SHALL capture it and advance one state (S_O advances to COMMIT).
REQ-018 Validity: digit>9 is always invalid.
REQ-019 Validity: H tens is valid iff tens*10 <= HOUR_MAX.
REQ-020 Validity: H ones is valid iff captured_tens*10+ones <= HOUR_MAX.
REQ-021 Validity: M and S tens are valid iff <= 5; M and S ones are valid iff <= 9.
REQ-022 An invalid digit SHALL leave the state and registers unchanged and SHALL pulse entry_err for exactly one cycle, in the cycle after the key_enter.
REQ-023 key_cancel in any non-IDLE state, including COMMIT, SHALL return to IDLE next cycle with no load pulse; cancel SHALL win over a simultaneous key_enter.
REQ-024 key_start while busy SHALL be ignored.
REQ-025 COMMIT SHALL last exactly one cycle and assert load.
REQ-026 In COMMIT, hour_load, min_load and sec_load SHALL equal tens*10+ones of the captured digits, computed in at least 7 bits and truncated to 6; the FSM SHALL then return to IDLE.
REQ-027 Latency: load SHALL be high in the cycle immediately after the key_enter that accepted the S ones digit.
REQ-028 *_load outputs SHALL hold their last committed values outside COMMIT; only COMMIT updates them.
REQ-029 pos SHALL reflect the registered state combinationally (COMMIT reports 5).

Reset
REQ-030 While rst is high at a clock edge, the FSM SHALL go to IDLE.
REQ-031 On reset, digit registers and hour_load/min_load/sec_load SHALL be 0.
REQ-032 On reset, load, entry_err and busy SHALL be 0 and pos SHALL be 7.
REQ-033 rst SHALL take priority over every key input, including during COMMIT; an aborted session SHALL produce no load pulse.

Verification
REQ-034 start, digits 1,3,4,5,0,9 -> one load pulse with hour=13, min=45, sec=9; busy falls with the return to IDLE; pos steps 0..5.
REQ-035 HOUR_MAX=23: start, digit 2, then digit 4 -> entry_err pulses, pos stays 1; then digit 3,0,0,5,9 -> hour=23, min=0, sec=59.
REQ-036 start, 1,2, then M tens digit 6 -> err; digit 11 (0xB) at M ones -> err; the session completes after valid digits are supplied.
REQ-037 start, 0,8,3,0 then key_cancel together with key_enter -> IDLE, no load, *_load keep previous values; key_start ignored mid-session.
REQ-038 rst asserted in the COMMIT cycle -> load=0, all outputs 0, pos=7 next cycle.
REQ-039 HOUR_MAX=12: digit 1 then 3 in the hour field -> rejected; digit 2 -> accepted; completing the session gives hour=12.
